spike_aer_encoder: RTL and testbench
====================================

// Module: spike_aer_encoder
// PURPOSE
//  Collects per-cycle spike pulses from a bank of neurons and serialises them into
//  address-event (AER) words: neuron index plus coarse timestamp.
//  Sits directly downstream of the neuron array; each neuron's spike output drives one spikes_i bit.
//  A round-robin arbiter feeds a FIFO with a valid/ready output toward the router or host link.
// PARAMETERS
//  NUM_NEURONS  16  number of spike inputs (>=2)
//  FIFO_DEPTH    8  AER FIFO entries (power of 2, >=2)
//  TS_W          8  timestamp width; wraps modulo 2^TS_W
//  DROP_W        8  width of the saturating dropped-event counter
//  ADDR_W   derived localparam, $clog2(NUM_NEURONS)
// PORTS
//  clk_i        in   1            single clock, all logic on rising edge
//  rst_ni       in   1            asynchronous, active-low reset
//  spikes_i     in   NUM_NEURONS  spike pulses; bit i high = one event from neuron i this cycle
//  tick_i       in   1            timestep strobe; advances the timestamp
//  aer_valid_o  out  1            FIFO head holds a valid event
//  aer_ready_i  in   1            consumer accepts the head when valid&ready
//  aer_addr_o   out  ADDR_W       neuron index of the head event
//  aer_time_o   out  TS_W         timestamp of the head event
//  fifo_full_o  out  1            FIFO occupancy == FIFO_DEPTH
//  drop_cnt_o   out  DROP_W       saturating count of cycles in which >=1 event was lost
// BEHAVIOUR
//  Reset (rst_ni=0, async): pending, timestamp, FIFO pointers/count, RR pointer and drop_cnt all clear to 0.
//   Outputs read 0: aer_valid_o=0, fifo_full_o=0, drop_cnt_o=0.
//   Reset mid-operation discards all queued and pending events.
//  Timestamp ts_r: increments by 1 on each cycle with tick_i=1; wraps from 2^TS_W-1 to 0.
//  Pending: pending_r[i] is set at the edge where spikes_i[i]=1.
//   pending_r[i] is cleared at the edge where neuron i is granted and pushed.
//   Grant of i and a new spikes_i[i] in the same cycle: pending_r[i] stays 1 (new event queued, no drop).
//  Drop rule: spikes_i[i]=1 while pending_r[i]=1 and i is not pushed that cycle -> the new event is lost.
//   drop_cnt increments by 1 per cycle with >=1 such loss.
//   drop_cnt saturates at 2^DROP_W-1 and never wraps.
//  Arbiter: combinational, over pending_r only.
//   Grants the lowest index >= rr_ptr that is pending, else wraps to the lowest pending index.
//   A push occurs when any bit is pending and the registered count < FIFO_DEPTH.
//   Full with a pop in the same cycle: no push that cycle; the slot is reused next cycle.
//   On push, rr_ptr <= (grant+1) mod NUM_NEURONS; otherwise rr_ptr holds.
//  Push writes {grant index, ts_r current value} into the FIFO. At most one push per cycle.
//  FIFO: pop when aer_valid_o && aer_ready_i. Simultaneous push and pop leaves count unchanged.
//   aer_valid_o = (count != 0). aer_addr_o and aer_time_o show the head entry.
//   Head is stable while valid && !ready. No combinational path from aer_ready_i to aer_valid_o.
//  While full, pending bits are held (not dropped); losses occur only by the drop rule above.
//  Latency, empty FIFO with a lone spike in cycle 0:
//   pending in cycle 1; push at the end of cycle 1; aer_valid_o=1 in cycle 2.
//   aer_time_o = ts_r value of cycle 1.
//  Throughput: 1 event/cycle sustained when the consumer is always ready.
// TESTING
//  1. Reset, ts_r=3, spikes_i=16'h0020 for 1 cycle, ready=1
//     -> cycle 2: valid=1, addr=5, time=3; valid=0 in cycle 3.
//  2. spikes_i=16'h8001 in one cycle, rr_ptr=0, ready=1
//     -> events addr 0 then addr 15 on consecutive cycles; drop_cnt=0.
//  3. ready=0; single spikes to neurons 0..9, one per cycle
//     -> fifo_full_o=1 after 8 pushes; neurons 8,9 stay pending.
//     -> raise ready: all 10 are delivered in order 0..9, drop_cnt=0.
//  4. ready=0 and FIFO full; spike neuron 2 twice, 3 cycles apart
//     -> drop_cnt=1; neuron 2 is delivered once after the drain.
//  5. Apply 2^TS_W+2 tick_i pulses, then one spike -> aer_time_o=2 (wrap); force 300 drop cycles -> drop_cnt_o=255.
//  6. 3 events queued, rst_ni pulsed low mid-transfer
//     -> aer_valid_o=0 immediately (async); no stale events after release.

Source files
------------

// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder
// Turns per-cycle neuron spike pulses into address-event words {neuron index, timestamp}.
// One pending flag per neuron holds a spike until the round-robin arbiter can push it
// into a small FIFO. The FIFO drives a valid/ready stream toward the router or host link.
// A spike that arrives while that neuron's previous event is still waiting is lost.
// Those losses are tallied in a saturating counter.

module spike_aer_encoder #(
  parameter  int NUM_NEURONS = 16,
  parameter  int FIFO_DEPTH  = 8,
  parameter  int TS_W        = 8,
  parameter  int DROP_W      = 8,
  localparam int ADDR_W      = $clog2(NUM_NEURONS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_NEURONS-1:0] spikes_i,
  input  logic                   tick_i,
  output logic                   aer_valid_o,
  input  logic                   aer_ready_i,
  output logic [ADDR_W-1:0]      aer_addr_o,
  output logic [TS_W-1:0]        aer_time_o,
  output logic                   fifo_full_o,
  output logic [DROP_W-1:0]      drop_cnt_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [NUM_NEURONS-1:0] pending_r;
  logic [TS_W-1:0]        ts_r;
  logic [ADDR_W-1:0]      rr_ptr_r;
  logic [DROP_W-1:0]      drop_cnt_r;
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [CNT_W-1:0]       count_r;

  logic [ADDR_W-1:0]      addr_mem [FIFO_DEPTH];
  logic [TS_W-1:0]        time_mem [FIFO_DEPTH];

  logic [ADDR_W-1:0]      grant;
  logic [ADDR_W-1:0]      grant_hi;
  logic [ADDR_W-1:0]      grant_lo;
  logic                   found_hi;
  logic                   push;
  logic                   pop;
  logic [NUM_NEURONS-1:0] grant_onehot;
  logic                   drop_any;

  // Round-robin pick: lowest pending index at or above rr_ptr, else the lowest pending overall.
  always_comb begin
    grant_hi = '0;
    grant_lo = '0;
    found_hi = 1'b0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (pending_r[i]) begin
        grant_lo = ADDR_W'(i);
        if (i >= int'(rr_ptr_r)) begin
          grant_hi = ADDR_W'(i);
          found_hi = 1'b1;
        end
      end
    end
    grant = found_hi ? grant_hi : grant_lo;
  end

  // Push and pop decisions use only registered state. Ready therefore never reaches valid combinationally.
  always_comb begin
    push         = (|pending_r) && (count_r != CNT_W'(FIFO_DEPTH));
    pop          = aer_valid_o && aer_ready_i;
    grant_onehot = push ? (NUM_NEURONS'(1) << grant) : '0;
    drop_any     = |(spikes_i & pending_r & ~grant_onehot);
  end

  // Pending flags, timestamp, arbiter pointer and loss counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_r  <= '0;
      ts_r       <= '0;
      rr_ptr_r   <= '0;
      drop_cnt_r <= '0;
    end else begin
      pending_r <= spikes_i | (pending_r & ~grant_onehot);
      if (tick_i) begin
        ts_r <= ts_r + TS_W'(1);
      end
      if (push) begin
        rr_ptr_r <= (grant == ADDR_W'(NUM_NEURONS - 1)) ? '0 : grant + ADDR_W'(1);
      end
      if (drop_any && (drop_cnt_r != '1)) begin
        drop_cnt_r <= drop_cnt_r + DROP_W'(1);
      end
    end
  end

  // FIFO bookkeeping; the depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage. No reset is needed because valid gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_ptr_r] <= grant;
      time_mem[wr_ptr_r] <= ts_r;
    end
  end

  assign aer_valid_o = (count_r != '0);
  assign fifo_full_o = (count_r == CNT_W'(FIFO_DEPTH));
  assign aer_addr_o  = addr_mem[rd_ptr_r];
  assign aer_time_o  = time_mem[rd_ptr_r];
  assign drop_cnt_o  = drop_cnt_r;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// tb_spike_aer_encoder
// Directed bench for spike_aer_encoder with its default parameters: 16 neurons, 8-deep FIFO, 8-bit timestamp and drop counter.
// Inputs change 1 time unit after each rising edge, and outputs are sampled at that same point.

module tb_spike_aer_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] spikes;
  logic        tick;
  logic        aer_ready;
  logic        aer_valid;
  logic [3:0]  aer_addr;
  logic [7:0]  aer_time;
  logic        fifo_full;
  logic [7:0]  drop_cnt;

  int vectors     = 0;
  int miscompares = 0;

  spike_aer_encoder #(
    .NUM_NEURONS(16),
    .FIFO_DEPTH (8),
    .TS_W       (8),
    .DROP_W     (8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .spikes_i   (spikes),
    .tick_i     (tick),
    .aer_valid_o(aer_valid),
    .aer_ready_i(aer_ready),
    .aer_addr_o (aer_addr),
    .aer_time_o (aer_time),
    .fifo_full_o(fifo_full),
    .drop_cnt_o (drop_cnt)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] s, input logic t, input logic r);
    spikes    = s;
    tick      = t;
    aer_ready = r;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    applyStimulus(16'h0000, 1'b0, 1'b0);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Hold ready high and check that the delivered addresses match exp_q in order, with a bounded cycle budget.
  task automatic drainExpect(input string tag, input int exp_q[$]);
    int idx;
    idx = 0;
    applyStimulus(16'h0000, 1'b0, 1'b1);
    for (int c = 0; c < 80 && idx < exp_q.size(); c++) begin
      if (aer_valid) begin
        checkOutput(tag, 32'(aer_addr), exp_q[idx]);
        idx++;
      end
      step();
    end
    checkOutput({tag, "_count"}, idx, exp_q.size());
  endtask

  initial begin
    int q3[$];
    int q4[$];

    // Reset state.
    doReset();
    checkOutput("rst_valid", 32'(aer_valid), 0);
    checkOutput("rst_full", 32'(fifo_full), 0);
    checkOutput("rst_drop", 32'(drop_cnt), 0);

    // Lone spike latency. The timestamp is 3 after three ticks.
    applyStimulus(16'h0000, 1'b1, 1'b1);
    repeat (3) step();
    applyStimulus(16'h0020, 1'b0, 1'b1);
    step();
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("t1_c1_valid", 32'(aer_valid), 0);
    step();
    checkOutput("t1_c2_valid", 32'(aer_valid), 1);
    checkOutput("t1_c2_addr", 32'(aer_addr), 5);
    checkOutput("t1_c2_time", 32'(aer_time), 3);
    step();
    checkOutput("t1_c3_valid", 32'(aer_valid), 0);

    // Two simultaneous spikes with rr_ptr at 0: neuron 0 is delivered, then neuron 15.
    doReset();
    applyStimulus(16'h8001, 1'b0, 1'b1);
    step();
    applyStimulus(16'h0000, 1'b0, 1'b1);
    step();
    checkOutput("t2_first_valid", 32'(aer_valid), 1);
    checkOutput("t2_first_addr", 32'(aer_addr), 0);
    step();
    checkOutput("t2_second_valid", 32'(aer_valid), 1);
    checkOutput("t2_second_addr", 32'(aer_addr), 15);
    step();
    checkOutput("t2_empty", 32'(aer_valid), 0);
    checkOutput("t2_drop", 32'(drop_cnt), 0);

    // Fill while stalled. Neurons 8 and 9 wait in pending, and all ten drain in order.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(16'(1 << k), 1'b0, 1'b0);
      step();
    end
    applyStimulus(16'h0000, 1'b0, 1'b0);
    checkOutput("t3_full", 32'(fifo_full), 1);
    checkOutput("t3_head", 32'(aer_addr), 0);
    for (int k = 0; k < 10; k++) q3.push_back(k);
    drainExpect("t3_order", q3);
    step();
    checkOutput("t3_empty", 32'(aer_valid), 0);
    checkOutput("t3_full_clear", 32'(fifo_full), 0);
    checkOutput("t3_drop", 32'(drop_cnt), 0);

    // Full FIFO, neuron 2 spiked twice 3 cycles apart. One loss is counted and one event is delivered.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(16'(1 << (k + 4)), 1'b0, 1'b0);
      step();
    end
    applyStimulus(16'h0000, 1'b0, 1'b0);
    step();
    checkOutput("t4_full", 32'(fifo_full), 1);
    applyStimulus(16'h0004, 1'b0, 1'b0);
    step();
    applyStimulus(16'h0000, 1'b0, 1'b0);
    step();
    step();
    checkOutput("t4_no_drop_yet", 32'(drop_cnt), 0);
    applyStimulus(16'h0004, 1'b0, 1'b0);
    step();
    applyStimulus(16'h0000, 1'b0, 1'b0);
    checkOutput("t4_drop", 32'(drop_cnt), 1);
    for (int k = 4; k < 12; k++) q4.push_back(k);
    q4.push_back(2);
    drainExpect("t4_order", q4);
    repeat (3) step();
    checkOutput("t4_empty", 32'(aer_valid), 0);
    checkOutput("t4_drop_hold", 32'(drop_cnt), 1);

    // Timestamp wrap: 258 ticks from 0 leave the timestamp at 2.
    doReset();
    applyStimulus(16'h0000, 1'b1, 1'b0);
    repeat (258) step();
    applyStimulus(16'h0008, 1'b0, 1'b1);
    step();
    applyStimulus(16'h0000, 1'b0, 1'b1);
    step();
    checkOutput("t5_valid", 32'(aer_valid), 1);
    checkOutput("t5_addr", 32'(aer_addr), 3);
    checkOutput("t5_time", 32'(aer_time), 2);
    step();
    checkOutput("t5_empty", 32'(aer_valid), 0);

    // Drop saturation: neuron 0 fires every cycle into a stalled, full FIFO for more than 300 cycles.
    applyStimulus(16'h0001, 1'b0, 1'b0);
    repeat (320) step();
    checkOutput("t5_drop_sat", 32'(drop_cnt), 255);
    checkOutput("t5_full", 32'(fifo_full), 1);
    repeat (5) step();
    checkOutput("t5_drop_nowrap", 32'(drop_cnt), 255);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    repeat (20) step();
    checkOutput("t5_drained", 32'(aer_valid), 0);

    // Asynchronous reset in the middle of a transfer.
    doReset();
    applyStimulus(16'h000E, 1'b0, 1'b0);
    step();
    applyStimulus(16'h0000, 1'b0, 1'b0);
    repeat (4) step();
    checkOutput("t6_valid", 32'(aer_valid), 1);
    checkOutput("t6_head", 32'(aer_addr), 1);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    step();
    checkOutput("t6_next_head", 32'(aer_addr), 2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_valid", 32'(aer_valid), 0);
    checkOutput("t6_async_full", 32'(fifo_full), 0);
    checkOutput("t6_async_drop", 32'(drop_cnt), 0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      checkOutput("t6_no_stale", 32'(aer_valid), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
